// File: rtl/counter_ud_mod_if.sv
// Control and status bundle for counter_ud_mod: the master drives CE/UP/LD/D,
// and the slave (the counter) returns O/COUT/TC.
interface counter_ud_mod_if #(
  parameter int WIDTH = 4
);
  logic             CE;
  logic             UP;
  logic             LD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] O;
  logic             COUT;
  logic             TC;

  modport master (output CE, UP, LD, D, input  O, COUT, TC);
  modport slave  (input  CE, UP, LD, D, output O, COUT, TC);
endinterface

// File: rtl/counter_ud_mod.sv
// Up/down modulo-(MAX+1) counter with a synchronous load and a registered wrap flag.
// Define COUNTER_UD_MOD_SATURATE_EN to make the counter hold at its limits instead of wrapping.
module counter_ud_mod #(
  parameter int          WIDTH = 4,
  parameter int unsigned MAX   = 15,
  parameter int unsigned INIT  = 0
) (
  input  logic              CLK,
  input  logic              RESET,
  counter_ud_mod_if.slave   bus
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);

  logic [WIDTH-1:0] o_q, o_d;
  logic             cout_q, cout_d;
  logic             at_max, at_zero;

  // A load value above the modulus is pulled back to MAX so O never leaves range.
  function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] d);
    return (d > MAX_V) ? MAX_V : d;
  endfunction

  assign at_max  = (o_q == MAX_V);
  assign at_zero = (o_q == '0);

  always_comb begin
    o_d    = o_q;
    cout_d = 1'b0;
    if (bus.LD) begin
      o_d = clamp_load(bus.D);
    end else if (bus.CE) begin
      if (bus.UP) begin
        if (at_max) begin
`ifdef COUNTER_UD_MOD_SATURATE_EN
          o_d    = o_q;
`else
          o_d    = '0;
`endif
          cout_d = 1'b1;
        end else begin
          o_d = o_q + ONE_V;
        end
      end else begin
        if (at_zero) begin
`ifdef COUNTER_UD_MOD_SATURATE_EN
          o_d    = o_q;
`else
          o_d    = MAX_V;
`endif
          cout_d = 1'b1;
        end else begin
          o_d = o_q - ONE_V;
        end
      end
    end
  end

  // Register stage: count and wrap flag
  always_ff @(posedge CLK) begin
    if (RESET) begin
      o_q    <= INIT_V;
      cout_q <= 1'b0;
    end else begin
      o_q    <= o_d;
      cout_q <= cout_d;
    end
  end

  assign bus.O    = o_q;
  assign bus.COUT = cout_q;
  // Terminal count follows UP immediately, whether or not CE is asserted.
  assign bus.TC   = (bus.UP & at_max) | (~bus.UP & at_zero);

endmodule

// File: tb/tb_counter_ud_mod.sv
// Bench for counter_ud_mod (WIDTH=4, MAX=9, INIT=3): directed cases plus random
// traffic compared against a modular-arithmetic reference model.
module tb_counter_ud_mod;

  localparam int          W  = 4;
  localparam int unsigned MX = 9;
  localparam int unsigned IN = 3;

  logic CLK = 1'b0;
  logic RESET;

  counter_ud_mod_if #(.WIDTH(W)) bus ();

  counter_ud_mod #(.WIDTH(W), .MAX(MX), .INIT(IN)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  int          total = 0;
  int          bad   = 0;
  int unsigned m_o   = 0;
  int unsigned m_c   = 0;

  task automatic check_val(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int unsigned exp_tc(input int unsigned o, input bit up);
    return ((up && o == MX) || (!up && o == 0)) ? 1 : 0;
  endfunction

  // Apply one set of inputs, advance the model, clock once, then compare.
  task automatic step(input bit rst, input bit ld, input bit ce, input bit up, input int unsigned d);
    bit limit;
    RESET  = rst;
    bus.LD = ld;
    bus.CE = ce;
    bus.UP = up;
    bus.D  = d[W-1:0];
    if (rst) begin
      m_o = IN; m_c = 0;
    end else if (ld) begin
      m_o = (d > MX) ? MX : d; m_c = 0;
    end else if (ce) begin
      limit = up ? (m_o == MX) : (m_o == 0);
      m_c   = limit ? 1 : 0;
`ifdef COUNTER_UD_MOD_SATURATE_EN
      if (!limit) m_o = up ? m_o + 1 : m_o - 1;
`else
      m_o = up ? (m_o + 1) % (MX + 1) : (m_o + MX) % (MX + 1);
`endif
    end else begin
      m_c = 0;
    end
    @(posedge CLK);
    #1;
    check_val("o_model", bus.O, m_o);
    check_val("cout_model", bus.COUT, m_c);
    check_val("tc_model", bus.TC, exp_tc(m_o, up));
  endtask

  int unsigned seq_o[7];
  int unsigned seq_c[7];

  initial begin
    RESET = 1'b0; bus.LD = 1'b0; bus.CE = 1'b0; bus.UP = 1'b1; bus.D = '0;
    @(posedge CLK); #1;

    // Reset wins over load and count enable
    step(1, 1, 1, 1, 7);
    check_val("rst_o", bus.O, 3);
    check_val("rst_cout", bus.COUT, 0);

    // Count up 3 -> 9 then limit
    seq_o = '{4, 5, 6, 7, 8, 9, 0};
    seq_c = '{0, 0, 0, 0, 0, 0, 1};
`ifdef COUNTER_UD_MOD_SATURATE_EN
    seq_o[6] = 9;
`endif
    for (int i = 0; i < 7; i++) begin
      step(0, 0, 1, 1, 0);
      check_val($sformatf("up_o%0d", i), bus.O, seq_o[i]);
      check_val($sformatf("up_c%0d", i), bus.COUT, seq_c[i]);
      if (i == 5) check_val("tc_at9", bus.TC, 1);
    end

    // Count down from 1 through 0
    step(0, 1, 0, 0, 1);
    seq_o[0] = 0; seq_o[1] = 9; seq_o[2] = 8;
    seq_c[0] = 0; seq_c[1] = 1; seq_c[2] = 0;
`ifdef COUNTER_UD_MOD_SATURATE_EN
    seq_o[1] = 0; seq_o[2] = 0; seq_c[2] = 1;
`endif
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0);
      check_val($sformatf("dn_o%0d", i), bus.O, seq_o[i]);
      check_val($sformatf("dn_c%0d", i), bus.COUT, seq_c[i]);
    end

    // Load clamping and load priority over CE
    step(0, 1, 1, 1, 14);
    check_val("ld_clamp", bus.O, 9);
    check_val("ld_cout", bus.COUT, 0);
    step(0, 1, 1, 0, 5);
    check_val("ld_5", bus.O, 5);

    // Direction changes take effect immediately; reset aborts
    step(0, 1, 0, 1, 6);
    step(0, 0, 1, 1, 0); check_val("dir_7a", bus.O, 7);
    step(0, 0, 1, 0, 0); check_val("dir_6", bus.O, 6);
    step(0, 0, 1, 1, 0); check_val("dir_7b", bus.O, 7);
    step(1, 0, 1, 1, 0); check_val("mid_rst", bus.O, 3);
    step(0, 0, 1, 1, 0); check_val("resume", bus.O, 4);

    // Hold with CE low
    step(0, 0, 0, 1, 0); check_val("hold", bus.O, 4);

`ifdef COUNTER_UD_MOD_SATURATE_EN
    step(0, 1, 0, 1, 9);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 0);
      check_val($sformatf("sat_o%0d", i), bus.O, 9);
      check_val($sformatf("sat_c%0d", i), bus.COUT, 1);
    end
    step(0, 0, 1, 0, 0);
    check_val("sat_dn_o", bus.O, 8);
    check_val("sat_dn_c", bus.COUT, 0);
`endif

    // Random traffic against the model, with TC probed combinationally
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 3) != 0), $urandom_range(0, 1) == 1,
           $urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) begin
        bus.UP = ~bus.UP;
        #1;
        check_val("tc_comb", bus.TC, exp_tc(m_o, bus.UP));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
